// File: rtl/decerr_slave.sv
// ---------------------------------------------------------------------------
// decerr_slave
// Default AXI4 responder for a crossbar: every write and read that lands on
// an unmapped address is completed with DECERR (2'b11). Write and read paths
// are independent FSMs, each holding at most one outstanding transaction.
//
// Ports
//   ACLK, ARESET          clock (rising edge) and asynchronous active-high reset
//   AW*  (in)  / AWREADY  write address; only AWID is used
//   W*   (in)  / WREADY   write data; only WLAST/WVALID are used
//   BID, BRESP, BVALID    write response (out), BREADY (in)
//   AR*  (in)  / ARREADY  read address; ARID and ARLEN are used
//   RID, RDATA, RRESP,    read data (out), always zero data with DECERR
//   RLAST, RVALID         RREADY (in)
// ---------------------------------------------------------------------------
module decerr_slave #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   localparam logic [1:0] RESP_DECERR = 2'b11;

   w_state_t              w_state_r, w_state_s;
   r_state_t              r_state_r, r_state_s;
   logic                  rst_done_r;
   logic [ID_WIDTH-1:0]   bid_r;
   logic [ID_WIDTH-1:0]   rid_r;
   logic [7:0]            beat_cnt_r;
   logic                  aw_hs_s;
   logic                  ar_hs_s;
   logic                  r_hs_s;

   // Address, length (write side), data and strobes carry no meaning here.
   logic unused_s;
   assign unused_s = ^{AWADDR, AWLEN, WDATA, WSTRB, ARADDR};

   // Ready-gate: address channels open one edge after reset release.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rst_done_r <= 1'b0;
      end else begin
         rst_done_r <= 1'b1;
      end
   end

   // State registers for both FSMs.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_r <= W_IDLE;
         r_state_r <= R_IDLE;
      end else begin
         w_state_r <= w_state_s;
         r_state_r <= r_state_s;
      end
   end

   // Write FSM next state and write-channel handshake outputs.
   always_comb begin
      w_state_s = w_state_r;
      AWREADY   = 1'b0;
      WREADY    = 1'b0;
      BVALID    = 1'b0;
      BRESP     = 2'b00;
      BID       = {ID_WIDTH{1'b0}};
      aw_hs_s   = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            AWREADY = rst_done_r;
            aw_hs_s = AWVALID && rst_done_r;
            if (aw_hs_s) begin
               w_state_s = W_DATA;
            end else begin
               w_state_s = W_IDLE;
            end
         end
         W_DATA: begin
            // Beat count is ignored; only WLAST closes the burst.
            WREADY = 1'b1;
            if (WVALID && WLAST) begin
               w_state_s = W_RESP;
            end else begin
               w_state_s = W_DATA;
            end
         end
         W_RESP: begin
            BVALID = 1'b1;
            BRESP  = RESP_DECERR;
            BID    = bid_r;
            if (BREADY) begin
               w_state_s = W_IDLE;
            end else begin
               w_state_s = W_RESP;
            end
         end
         default: begin
            w_state_s = W_IDLE;
         end
      endcase
   end

   // Read FSM next state and read-channel handshake outputs.
   always_comb begin
      r_state_s = r_state_r;
      ARREADY   = 1'b0;
      RVALID    = 1'b0;
      RLAST     = 1'b0;
      RRESP     = 2'b00;
      RID       = {ID_WIDTH{1'b0}};
      RDATA     = {DATA_WIDTH{1'b0}};
      ar_hs_s   = 1'b0;
      r_hs_s    = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            ARREADY = rst_done_r;
            ar_hs_s = ARVALID && rst_done_r;
            if (ar_hs_s) begin
               r_state_s = R_DATA;
            end else begin
               r_state_s = R_IDLE;
            end
         end
         R_DATA: begin
            RVALID = 1'b1;
            RLAST  = (beat_cnt_r == 8'd0);
            RRESP  = RESP_DECERR;
            RID    = rid_r;
            r_hs_s = RREADY;
            if (RREADY && (beat_cnt_r == 8'd0)) begin
               r_state_s = R_IDLE;
            end else begin
               r_state_s = R_DATA;
            end
         end
         default: begin
            r_state_s = R_IDLE;
         end
      endcase
   end

   // Capture the write ID at AW acceptance; it is returned on B.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         bid_r <= {ID_WIDTH{1'b0}};
      end else if (aw_hs_s) begin
         bid_r <= AWID;
      end else begin
         bid_r <= bid_r;
      end
   end

   // Capture read ID and remaining-beat count; the count stops at zero so
   // ARLEN=255 yields exactly 256 beats.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rid_r      <= {ID_WIDTH{1'b0}};
         beat_cnt_r <= 8'd0;
      end else if (ar_hs_s) begin
         rid_r      <= ARID;
         beat_cnt_r <= ARLEN;
      end else if (r_hs_s && (beat_cnt_r != 8'd0)) begin
         rid_r      <= rid_r;
         beat_cnt_r <= beat_cnt_r - 8'd1;
      end else begin
         rid_r      <= rid_r;
         beat_cnt_r <= beat_cnt_r;
      end
   end

endmodule

// File: tb/tb_decerr_slave.sv
module tb_decerr_slave;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [3:0]  AWID = 4'h0;
   logic [31:0] AWADDR = 32'h0;
   logic [7:0]  AWLEN = 8'h0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = 32'h0;
   logic [3:0]  WSTRB = 4'h0;
   logic        WLAST = 1'b0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [3:0]  ARID = 4'h0;
   logic [31:0] ARADDR = 32'h0;
   logic [7:0]  ARLEN = 8'h0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY = 1'b0;

   decerr_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: queues of accepted-but-unfinished work.
   typedef struct {
      logic [3:0] id;
      logic       last;
   } rbeat_t;

   logic [3:0] awq[$];   // accepted AW ids awaiting their WLAST
   logic [3:0] bq[$];    // responses owed on B
   rbeat_t     rq[$];    // R beats still owed
   logic       m_rst_done = 1'b0;

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         awq.delete();
         bq.delete();
         rq.delete();
         m_rst_done = 1'b0;
      end else begin : model_step
         logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
         aw_hs = AWVALID && m_rst_done && awq.size() == 0 && bq.size() == 0;
         w_hs  = WVALID && awq.size() != 0;
         b_hs  = BREADY && bq.size() != 0;
         ar_hs = ARVALID && m_rst_done && rq.size() == 0;
         r_hs  = RREADY && rq.size() != 0;
         if (b_hs) void'(bq.pop_front());
         if (w_hs && WLAST) bq.push_back(awq.pop_front());
         if (aw_hs) awq.push_back(AWID);
         if (r_hs) void'(rq.pop_front());
         if (ar_hs) begin
            for (int i = 0; i <= int'(ARLEN); i++) begin
               rq.push_back('{id: ARID, last: (i == int'(ARLEN))});
            end
         end
         m_rst_done = 1'b1;
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   logic cmp_en = 1'b0;
   always @(negedge ACLK) begin
      if (cmp_en) begin
         check("awready", AWREADY, m_rst_done && awq.size() == 0 && bq.size() == 0);
         check("wready",  WREADY,  awq.size() != 0);
         check("bvalid",  BVALID,  bq.size() != 0);
         check("bid",     BID,     bq.size() != 0 ? bq[0] : 4'h0);
         check("bresp",   BRESP,   bq.size() != 0 ? 2'b11 : 2'b00);
         check("arready", ARREADY, m_rst_done && rq.size() == 0);
         check("rvalid",  RVALID,  rq.size() != 0);
         check("rid",     RID,     rq.size() != 0 ? rq[0].id : 4'h0);
         check("rlast",   RLAST,   rq.size() != 0 ? rq[0].last : 1'b0);
         check("rresp",   RRESP,   rq.size() != 0 ? 2'b11 : 2'b00);
         check("rdata",   RDATA,   32'h0);
      end
   end

   // Handshake counters observed on the DUT side.
   int r_cnt = 0, rlast_cnt = 0, rlast_at = 0, b_cnt = 0;
   always @(posedge ACLK) begin
      if (!ARESET) begin
         if (RVALID && RREADY) begin
            r_cnt++;
            if (RLAST) begin
               rlast_cnt++;
               rlast_at = r_cnt;
            end
         end
         if (BVALID && BREADY) b_cnt++;
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic clr_counts();
      r_cnt = 0; rlast_cnt = 0; rlast_at = 0; b_cnt = 0;
   endtask

   initial begin
      tick();
      cmp_en = 1'b1;
      tick();
      check("reset_awready", AWREADY, 1'b0);
      check("reset_rvalid",  RVALID,  1'b0);
      ARESET = 1'b0;
      #1;
      check("rel_awready_0", AWREADY, 1'b0);
      tick();
      check("rel_awready_1", AWREADY, 1'b1);
      check("rel_arready_1", ARREADY, 1'b1);

      // Write burst of 4 beats, AWID=5
      clr_counts();
      BREADY = 1'b1; AWID = 4'h5; AWVALID = 1'b1; AWADDR = 32'hDEAD_0000; AWLEN = 8'd3;
      tick();
      AWVALID = 1'b0;
      check("wr_wready", WREADY, 1'b1);
      for (int i = 0; i < 4; i++) begin
         WVALID = 1'b1; WLAST = (i == 3); WDATA = 32'h100 + i; WSTRB = 4'hF;
         tick();
      end
      WVALID = 1'b0; WLAST = 1'b0;
      check("wr_bvalid", BVALID, 1'b1);
      check("wr_bid",    BID,    4'h5);
      check("wr_bresp",  BRESP,  2'b11);
      check("wr_awready_busy", AWREADY, 1'b0);
      tick();
      check("wr_awready_again", AWREADY, 1'b1);
      check("wr_b_count", b_cnt, 1);
      BREADY = 1'b0;

      // Read burst ARLEN=3, ARID=A
      clr_counts();
      ARID = 4'hA; ARLEN = 8'd3; ARVALID = 1'b1; RREADY = 1'b1;
      tick();
      ARVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rd_rvalid", RVALID, 1'b1);
         check("rd_rid",    RID,    4'hA);
         check("rd_rlast",  RLAST,  i == 3);
         tick();
      end
      check("rd_done", RVALID, 1'b0);
      check("rd_beats", r_cnt, 4);
      check("rd_rlast_cnt", rlast_cnt, 1);

      // Backpressure: single-beat read, then stalled write response
      clr_counts();
      RREADY = 1'b0; ARID = 4'h3; ARLEN = 8'd0; ARVALID = 1'b1;
      tick();
      ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_rvalid", RVALID, 1'b1);
         check("bp_rlast",  RLAST,  1'b1);
         check("bp_rid",    RID,    4'h3);
         tick();
      end
      RREADY = 1'b1;
      tick();
      check("bp_r_count", r_cnt, 1);
      check("bp_r_gone", RVALID, 1'b0);
      AWID = 4'h6; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b1; WLAST = 1'b1;
      tick();
      WVALID = 1'b0; WLAST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp_bvalid", BVALID, 1'b1);
         check("bp_bid",    BID,    4'h6);
         tick();
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      tick();
      check("bp_b_count", b_cnt, 1);

      // Concurrent AW and 256-beat AR in the same cycle
      clr_counts();
      AWID = 4'h1; AWVALID = 1'b1; ARID = 4'h2; ARLEN = 8'd255; ARVALID = 1'b1;
      RREADY = 1'b1; BREADY = 1'b1;
      tick();
      AWVALID = 1'b0; ARVALID = 1'b0;
      check("cc_wready", WREADY, 1'b1);
      check("cc_rvalid", RVALID, 1'b1);
      WVALID = 1'b1; WLAST = 1'b1;
      tick();
      WVALID = 1'b0; WLAST = 1'b0;
      for (int k = 0; k < 300 && r_cnt < 256; k++) tick();
      tick();
      check("cc_r_beats", r_cnt, 256);
      check("cc_rlast_at", rlast_at, 256);
      check("cc_rlast_cnt", rlast_cnt, 1);
      check("cc_b_count", b_cnt, 1);
      BREADY = 1'b0;

      // Early W before any AW
      clr_counts();
      WVALID = 1'b1; WLAST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("ew_wready", WREADY, 1'b0);
         tick();
      end
      AWID = 4'h7; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      check("ew_wready_open", WREADY, 1'b1);
      tick();
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      check("ew_bid", BID, 4'h7);
      tick();
      tick();
      check("ew_b_count", b_cnt, 1);
      BREADY = 1'b0;

      // Reset during beat 2 of an 8-beat read
      clr_counts();
      ARID = 4'h4; ARLEN = 8'd7; ARVALID = 1'b1; RREADY = 1'b1;
      tick();
      ARVALID = 1'b0;
      tick();
      check("rst_beat2_valid", RVALID, 1'b1);
      ARESET = 1'b1;
      #1;
      check("rst_rvalid_now", RVALID, 1'b0);
      tick();
      tick();
      ARESET = 1'b0;
      clr_counts();
      tick();
      check("rst_arready", ARREADY, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      check("rst_no_beats", r_cnt, 0);
      RREADY = 1'b0;

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decerr_slave.md
DECERR_SLAVE -- requirements
Module: decerr_slave

Interface
- REQ-001: Parameters SHALL be:
  - ID_WIDTH, default 4, AXI transaction ID width.
  - ADDR_WIDTH, default 32, AXI address width.
  - DATA_WIDTH, default 32, AXI data width.
- REQ-002: Ports SHALL be (name, direction, width, meaning):
  - ACLK, in, 1, the single clock; all logic on rising edge.
  - ARESET, in, 1, asynchronous active-high reset.
- REQ-003: Write address channel:
  - AWID, in, ID_WIDTH.
  - AWADDR, in, ADDR_WIDTH, ignored.
  - AWLEN, in, 8, ignored.
  - AWVALID, in, 1.
  - AWREADY, out, 1.
- REQ-004: Write data channel:
  - WDATA, in, DATA_WIDTH, ignored.
  - WSTRB, in, DATA_WIDTH/8, ignored.
  - WLAST, in, 1.
  - WVALID, in, 1.
  - WREADY, out, 1.
- REQ-005: Write response channel:
  - BID, out, ID_WIDTH.
  - BRESP, out, 2.
  - BVALID, out, 1.
  - BREADY, in, 1.
- REQ-006: Read address channel:
  - ARID, in, ID_WIDTH.
  - ARADDR, in, ADDR_WIDTH, ignored.
  - ARLEN, in, 8.
  - ARVALID, in, 1.
  - ARREADY, out, 1.
- REQ-007: Read data channel:
  - RID, out, ID_WIDTH.
  - RDATA, out, DATA_WIDTH.
  - RRESP, out, 2.
  - RLAST, out, 1.
  - RVALID, out, 1.
  - RREADY, in, 1.

Function
- REQ-008: The block SHALL act as the crossbar's default AXI4 responder for addresses matching no mapped slave, completing every transaction with DECERR (2'b11).
- REQ-009: The write FSM SHALL have three states and these transitions:
  - W_IDLE -> W_DATA on AWVALID&AWREADY; latch AWID.
  - W_DATA -> W_RESP on WVALID&WREADY&WLAST.
  - W_RESP -> W_IDLE on BVALID&BREADY.
- REQ-010: AWREADY SHALL be high only in W_IDLE with rst_done=1; WREADY only in W_DATA; BVALID only in W_RESP.
- REQ-011: W beat count SHALL be ignored; the burst ends solely on WLAST, and every W beat SHALL be accepted, including the first beat when WLAST=1.
- REQ-012: W beats presented while in W_IDLE SHALL NOT be accepted (WREADY=0).
- REQ-013: Write latency:
  - AW handshake in cycle N -> WREADY=1 in cycle N+1.
  - WLAST handshake in cycle M -> BVALID=1 in cycle M+1.
- REQ-014: While BVALID=1, BID SHALL equal the latched AWID and BRESP SHALL be 2'b11; BVALID, BID and BRESP SHALL hold stable until BREADY.
- REQ-015: The read FSM SHALL have two states and these transitions:
  - R_IDLE -> R_DATA on ARVALID&ARREADY; latch ARID; load the 8-bit beat counter with ARLEN.
  - R_DATA -> R_IDLE on RVALID&RREADY&RLAST.
- REQ-016: ARREADY SHALL be high only in R_IDLE with rst_done=1; RVALID only in R_DATA.
- REQ-017: Read latency: AR handshake in cycle N -> RVALID=1 in cycle N+1; exactly ARLEN+1 beats SHALL follow, RLAST=1 only on the beat where the counter equals 0.
- REQ-018: The counter SHALL decrement on each RVALID&RREADY; it SHALL NOT wrap (ARLEN=255 gives 256 beats, ARLEN=0 gives a single beat with RLAST=1).
- REQ-019: In R_DATA, RDATA SHALL be all zeros, RRESP 2'b11 and RID the latched ARID; RVALID, RDATA, RRESP, RID and RLAST SHALL hold stable while RREADY=0.
- REQ-020: Read and write FSMs SHALL be fully independent; simultaneous AW and AR handshakes in the same cycle SHALL both be accepted.
- REQ-021: Each FSM SHALL hold at most one outstanding transaction; a new AW/AR SHALL NOT be accepted until its own FSM returns to idle.
- REQ-022: The next transaction SHALL be accepted no earlier than the cycle after the final B or R handshake.

Reset
- REQ-023: While ARESET=1:
  - both FSMs SHALL be in idle.
  - rst_done SHALL be 0.
  - all outputs SHALL be 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, RID, BRESP, RRESP, RDATA.
- REQ-024: rst_done SHALL be set on the first ACLK edge after ARESET deasserts, so AWREADY and ARREADY first rise one cycle after deassertion.
- REQ-025: ARESET asserted mid-burst SHALL immediately abandon the transaction with no response issued after release.

Verification
- REQ-026: Write burst: AWID=4'h5, 4 W beats with WLAST on the 4th, BREADY=1 -> BVALID rises the cycle after the 4th beat, BID=5, BRESP=2'b11, AWREADY high again the cycle after the B handshake.
- REQ-027: Read burst: ARID=4'hA, ARLEN=3, RREADY=1 -> 4 consecutive beats, RDATA=0, RRESP=2'b11, RID=A, RLAST only on the 4th beat.
- REQ-028: Backpressure: ARLEN=0 with RREADY low for 5 cycles, then BREADY held low for 3 cycles on a separate write -> RVALID and BVALID and all payloads stay stable, and each completes exactly once.
- REQ-029: Concurrency: AW (AWID=1) and AR (ARID=2, ARLEN=255) handshake in the same cycle -> write completes independently, and exactly 256 R beats are delivered with RLAST on beat 256.
- REQ-030: Early W: WVALID=1 with WLAST=1 before any AW -> WREADY stays 0 until after the AW handshake; exactly one B is returned.
- REQ-031: Reset mid-operation: ARESET pulsed during beat 2 of an ARLEN=7 read -> RVALID=0 immediately, no further beats after release, ARREADY=1 one cycle after deassertion.
